pi_debounce: RTL

//  Conditions the raw, active-low board switches into a clean input word for the CPU's parallel input port (PI).
//  - Synchronises each bit to the CPU clock (CLK_16 domain at top level).
//  - Debounces each bit with a per-bit stability counter.
//  - Presents the debounced word active-high, with one-cycle rise/fall/change strobes for polling logic.
//  - Sits directly upstream of CPU.PI and replaces the direct loopback IN = OUT.

---
 rtl/cpu8_pkg.sv | 9 +
 rtl/deb_bit.sv | 56 +++++
 rtl/pi_debounce.sv | 45 ++++
 3 files changed

// File: rtl/cpu8_pkg.sv
// Shared word-level types and constants for the 8-bit CPU and its peripherals.
package cpu8_pkg;

  localparam int unsigned WORD_W         = 8;
  localparam int unsigned DEB_CYCLES_1MS = 16500;

  typedef logic [WORD_W-1:0] word_t;

endpackage

// File: rtl/deb_bit.sv
// One switch bit: synchroniser chain, stability counter, debounced level and
// registered rise/fall strobes.
module deb_bit
  import cpu8_pkg::*;
#(
  parameter int unsigned SYNC_STAGES   = 2,
  parameter int unsigned STABLE_CYCLES = DEB_CYCLES_1MS
) (
  input  logic CLK,
  input  logic nRESET,
  input  logic n_in,
  output logic level,
  output logic rise,
  output logic fall,
  output logic accept_c
);

  localparam int unsigned CNT_W = $clog2(STABLE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STABLE_CYCLES - 1);

  logic [SYNC_STAGES-1:0] sync_q;
  logic [CNT_W-1:0]       cnt_q;
  logic                   s_c;
  logic                   differ_c;

  // Last synchroniser stage, flipped to active-high.
  assign s_c      = ~sync_q[SYNC_STAGES-1];
  assign differ_c = (s_c != level);
  assign accept_c = differ_c && (cnt_q == CNT_MAX);

  always_ff @(posedge CLK) begin
    if (!nRESET) begin
      sync_q <= '1;
      cnt_q  <= '0;
      level  <= 1'b0;
      rise   <= 1'b0;
      fall   <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], n_in};
      rise   <= 1'b0;
      fall   <= 1'b0;
      if (!differ_c) begin
        cnt_q <= '0;
      end else if (cnt_q == CNT_MAX) begin
        // Level held long enough: accept it and strobe the matching edge.
        level <= s_c;
        cnt_q <= '0;
        rise  <= s_c;
        fall  <= ~s_c;
      end else begin
        cnt_q <= cnt_q + CNT_W'(1);
      end
    end
  end

endmodule

// File: rtl/pi_debounce.sv
// Debounced, active-high parallel-input word for the CPU PI port, with
// per-bit rise/fall strobes and a word-level change strobe.
module pi_debounce
  import cpu8_pkg::*;
#(
  parameter int unsigned WIDTH         = WORD_W,
  parameter int unsigned SYNC_STAGES   = 2,
  parameter int unsigned STABLE_CYCLES = DEB_CYCLES_1MS
) (
  input  logic             CLK,
  input  logic             nRESET,
  input  logic [WIDTH-1:0] nIN,
  output logic [WIDTH-1:0] PI,
  output logic [WIDTH-1:0] RISE,
  output logic [WIDTH-1:0] FALL,
  output logic             CHG
);

  logic [WIDTH-1:0] accept_c;

  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    deb_bit #(
      .SYNC_STAGES  (SYNC_STAGES),
      .STABLE_CYCLES(STABLE_CYCLES)
    ) u_deb_bit (
      .CLK     (CLK),
      .nRESET  (nRESET),
      .n_in    (nIN[i]),
      .level   (PI[i]),
      .rise    (RISE[i]),
      .fall    (FALL[i]),
      .accept_c(accept_c[i])
    );
  end

  // Registered so CHG lines up with the per-bit strobes.
  always_ff @(posedge CLK) begin
    if (!nRESET) begin
      CHG <= 1'b0;
    end else begin
      CHG <= |accept_c;
    end
  end

endmodule
